// File: rtl/rbcp_axi_read_bridge_if.sv
// AXI4-Lite read channel (AR + R) between the RBCP read bridge and the
// downstream 8-to-32 read adapter.
interface rbcp_axi_read_bridge_if;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rvalid, rresp
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rvalid, rresp
  );
endinterface

// File: rtl/rbcp_axi_read_bridge.sv
// SiTCP RBCP byte read -> single-beat 32-bit AXI4-Lite read, with a bounded
// per-transaction timeout and a saturating error counter.
module rbcp_axi_read_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rbcp_act,
  input  logic [31:0]                   rbcp_addr,
  input  logic                          rbcp_re,
  output logic [7:0]                    rbcp_rd,
  output logic                          rbcp_ack,
  rbcp_axi_read_bridge_if.master        m_axi,
  output logic [3:0]                    araddr_res,
  output logic [7:0]                    err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] araddr_q;
  logic [1:0]  lane_q;
  logic [3:0]  res_q;
  logic [15:0] tmo_cnt_q;
  logic        abort_q;
  logic [7:0]  rd_q;
  logic [7:0]  err_q;

  logic start;
  logic r_done;
  logic tmo;
  logic tmo_hit;
  logic aborting;
  logic err_inc;

  assign tmo_hit  = (tmo_cnt_q >= TMO_LIMIT);
  // An RBCP abort may land on the very edge that finishes the transfer.
  assign aborting = abort_q | ~rbcp_act;
  assign err_inc  = (r_done && (m_axi.rresp != 2'b00)) || tmo;

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    r_done  = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rbcp_re && rbcp_act) begin
          start   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_axi.arready) begin
          state_d = DATA;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = aborting ? IDLE : ACK;
        end
      end
      DATA: begin
        // The handshake has priority over a timeout expiring in the same cycle.
        if (m_axi.rvalid) begin
          r_done  = 1'b1;
          state_d = aborting ? IDLE : ACK;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = aborting ? IDLE : ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // here updates from values sampled before the edge, whatever the order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q  <= 32'h0;
      lane_q    <= 2'b00;
      res_q     <= 4'b0000;
      tmo_cnt_q <= 16'h0;
      abort_q   <= 1'b0;
    end else if (start) begin
      araddr_q  <= {rbcp_addr[31:2], 2'b00};
      lane_q    <= rbcp_addr[1:0];
      res_q     <= 4'b0001 << rbcp_addr[1:0];
      tmo_cnt_q <= 16'h0;
      abort_q   <= 1'b0;
    end else if (state_q == ADDR || state_q == DATA) begin
      if (tmo_cnt_q != 16'hFFFF) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
      if (!rbcp_act) begin
        abort_q <= 1'b1;
      end
    end
  end

  // An aborted read still completes on AXI but does not update the byte
  // presented to SiTCP, since no acknowledge follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 8'h00;
    end else if (r_done && !aborting) begin
      rd_q <= m_axi.rdata[8*lane_q +: 8];
    end else if (tmo && !aborting) begin
      rd_q <= TIMEOUT_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'h00;
    end else if (err_inc && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  // Orphan responses in IDLE are swallowed by holding rready high there.
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state_q == ADDR);
  assign m_axi.rready  = (state_q == IDLE) || (state_q == DATA);

  assign rbcp_rd    = rd_q;
  assign rbcp_ack   = (state_q == ACK);
  assign araddr_res = res_q;
  assign err_cnt    = err_q;

endmodule
